// File: rtl/adc_pkg.sv
// Shared types and helpers for the adc_sar_nb SAR ADC model.
package adc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } adc_sar_state_e;

  localparam int NBIT_MIN = 2;
  localparam int NBIT_MAX = 16;

  // Threshold voltage for a code: VL + LSB*code, with LSB = (VH-VL)/2**nbit.
  function automatic real code_to_v(input logic [31:0] code, input int nbit,
                                    input real vl, input real vh);
    real lsb;
    lsb = (vh - vl) / real'(64'd1 << nbit);
    return vl + lsb * real'(code);
  endfunction

endpackage

// File: rtl/adc_sar_dac.sv
// Combinational real-valued DAC: trial code -> VL + LSB*code.
module adc_sar_dac
  import adc_pkg::*;
#(
  parameter int  NBIT = 8,
  parameter real VH   = 3.0,
  parameter real VL   = -3.0
) (
  input  logic [NBIT-1:0] code,
  output real             v
);

  assign v = code_to_v(32'(code), NBIT, VL, VH);

endmodule

// File: rtl/adc_sar_nb.sv
// adc_sar_nb: behavioural N-bit SAR ADC, one bit per clock, start/busy/valid handshake.
// Define ADC_SAR_OVR_EN to add the ovr over/under-range output.
module adc_sar_nb
  import adc_pkg::*;
#(
  parameter int  NBIT = 8,
  parameter real VH   = 3.0,
  parameter real VL   = -3.0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pd,
  input  logic            start,
  input  real             in,
  output logic            busy,
  output logic            valid,
  output logic [NBIT-1:0] out
`ifdef ADC_SAR_OVR_EN
  ,
  output logic            ovr
`endif
);

  localparam int KW = $clog2(NBIT);
  localparam logic [NBIT-1:0] ONE = {{(NBIT-1){1'b0}}, 1'b1};

  if (NBIT < NBIT_MIN || NBIT > NBIT_MAX) begin : g_bad_nbit
    $error("adc_sar_nb: NBIT out of legal range");
  end

  adc_sar_state_e  state_q, state_d;
  real             vin_s_q, vin_s_d;
  logic [NBIT-1:0] result_q, result_d;
  logic [KW-1:0]   k_q, k_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [NBIT-1:0] out_q, out_d;
  logic [NBIT-1:0] trial;
  real             v_trial;
  logic            bit_hi;
`ifdef ADC_SAR_OVR_EN
  logic            ovr_q, ovr_d;
`endif

  adc_sar_dac #(
    .NBIT (NBIT),
    .VH   (VH),
    .VL   (VL)
  ) u_dac (
    .code (trial),
    .v    (v_trial)
  );

  assign trial  = result_q | (ONE << k_q);
  assign bit_hi = (vin_s_q >= v_trial);

  // Power-down behaves exactly like reset and aborts any conversion in flight.
  always_ff @(posedge clk or negedge rstn or posedge pd) begin
    if (!rstn || pd) begin
      state_q  <= IDLE;
      vin_s_q  <= 0.0;
      result_q <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
`ifdef ADC_SAR_OVR_EN
      ovr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      vin_s_q  <= vin_s_d;
      result_q <= result_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
`ifdef ADC_SAR_OVR_EN
      ovr_q    <= ovr_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    vin_s_d  = vin_s_q;
    result_d = result_q;
    k_d      = k_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    out_d    = out_q;
`ifdef ADC_SAR_OVR_EN
    ovr_d    = ovr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          vin_s_d  = in;
          result_d = '0;
          k_d      = KW'(NBIT - 1);
          busy_d   = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        result_d[k_q] = bit_hi;
        // The edge that decides bit 0 also publishes the result.
        if (k_q == '0) begin
          out_d   = result_d;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef ADC_SAR_OVR_EN
          ovr_d   = (vin_s_q < VL) || (vin_s_q >= VH);
`endif
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign out   = out_q;
`ifdef ADC_SAR_OVR_EN
  assign ovr   = ovr_q;
`endif

endmodule

// File: tb/tb_adc_sar_nb.sv
// Self-checking bench for adc_sar_nb (NBIT=6, VL=-3.0, VH=3.0) with a result scoreboard.
module tb_adc_sar_nb;

  localparam int  NBIT = 6;
  localparam real VH   = 3.0;
  localparam real VL   = -3.0;
  localparam real LSB  = 0.09375;

  typedef struct {
    logic [NBIT-1:0] code;
    logic            ovr;
  } exp_t;

  logic            clk;
  logic            rstn;
  logic            pd;
  logic            start;
  real             vin;
  logic            busy;
  logic            valid;
  logic [NBIT-1:0] out;
`ifdef ADC_SAR_OVR_EN
  logic            ovr;
`endif

  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  adc_sar_nb #(
    .NBIT (NBIT),
    .VH   (VH),
    .VL   (VL)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .pd    (pd),
    .start (start),
    .in    (vin),
    .busy  (busy),
    .valid (valid),
    .out   (out)
`ifdef ADC_SAR_OVR_EN
    ,
    .ovr   (ovr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Ideal flash transfer function, clamped at both ends.
  function automatic exp_t model(input real v);
    exp_t e;
    real  r;
    if (v < VL) begin
      e.code = '0;
    end else begin
      r = $floor((v - VL) / LSB);
      if (r > 63.0) e.code = 6'd63;
      else          e.code = NBIT'($rtoi(r));
    end
    e.ovr = (v < VL) || (v >= VH);
    return e;
  endfunction

  // Scoreboard: every valid pulse pops one expected result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid) begin
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL valid_busy_overlap: busy=%0b required 0", busy);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_valid: valid=1 with out=%0d, required no result", out);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.code) begin
          n_fail++;
          $display("[TB] FAIL sb_code: out=%0d required %0d", out, e.code);
        end
`ifdef ADC_SAR_OVR_EN
        n_checks++;
        if (ovr !== e.ovr) begin
          n_fail++;
          $display("[TB] FAIL sb_ovr: ovr=%0b required %0b", ovr, e.ovr);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input real v);
    vin   = v;
    start = 1'b1;
    exp_q.push_back(model(v));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    pd    = 1'b0;
    start = 1'b0;
    vin   = 0.0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: busy=%0b required 0", busy); end
    n_checks++;
    if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: valid=%0b required 0", valid); end
    n_checks++;
    if (out !== '0) begin n_fail++; $display("[TB] FAIL reset_out: out=%0d required 0", out); end
`ifdef ADC_SAR_OVR_EN
    n_checks++;
    if (ovr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovr: ovr=%0b required 0", ovr); end
`endif
    rstn = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy: busy=%0b required 0", busy); end
  endtask

  task automatic test_basic();
    int n;
    bit busy_drop;
    start_conv(0.0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_rise: busy=%0b required 1", busy); end
    n = 0;
    busy_drop = 1'b0;
    while (!valid && n < 20) begin
      tick();
      n++;
      if (!valid && busy !== 1'b1) busy_drop = 1'b1;
    end
    n_checks++;
    if (busy_drop !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_hold: busy dropped early, required high until valid"); end
    n_checks++;
    if (valid !== 1'b1 || n != 6) begin
      n_fail++;
      $display("[TB] FAIL basic_latency: valid=%0b after %0d clocks, required 1 after 6", valid, n);
    end
    n_checks++;
    if (out !== 6'd32) begin n_fail++; $display("[TB] FAIL basic_code: out=%0d required 32", out); end
    tick();
    n_checks++;
    if (valid !== 1'b0 || out !== 6'd32) begin
      n_fail++;
      $display("[TB] FAIL basic_hold: valid=%0b out=%0d, required valid 0 out 32", valid, out);
    end
  endtask

  task automatic test_thresholds();
    real             vals[3];
    logic [NBIT-1:0] codes[3];
    real             rv;
    int              n;
    vals  = '{0.09375, -0.05, 2.99};
    codes = '{6'd33, 6'd31, 6'd63};
    for (int i = 0; i < 3; i++) begin
      start_conv(vals[i]);
      wait_valid(20, n);
      n_checks++;
      if (valid !== 1'b1 || out !== codes[i]) begin
        n_fail++;
        $display("[TB] FAIL threshold_%0d: valid=%0b out=%0d, required valid 1 out %0d", i, valid, out, codes[i]);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      rv = real'($urandom_range(0, 5999)) / 1000.0 - 3.0;
      start_conv(rv);
      wait_valid(20, n);
      n_checks++;
      if (valid !== 1'b1) begin n_fail++; $display("[TB] FAIL random_timeout_%0d: valid=%0b required 1", i, valid); end
      tick();
    end
  endtask

  task automatic test_ovr();
    real             vals[2];
    logic [NBIT-1:0] codes[2];
    int              n;
    vals  = '{-3.5, 3.2};
    codes = '{6'd0, 6'd63};
    for (int i = 0; i < 2; i++) begin
      start_conv(vals[i]);
      wait_valid(20, n);
      n_checks++;
      if (valid !== 1'b1 || out !== codes[i]) begin
        n_fail++;
        $display("[TB] FAIL range_code_%0d: valid=%0b out=%0d, required valid 1 out %0d", i, valid, out, codes[i]);
      end
`ifdef ADC_SAR_OVR_EN
      n_checks++;
      if (ovr !== 1'b1) begin n_fail++; $display("[TB] FAIL range_ovr_%0d: ovr=%0b required 1", i, ovr); end
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    real vals[3];
    int  n;
    vals  = '{1.0, -2.0, 2.0};
    vin   = vals[0];
    start = 1'b1;
    exp_q.push_back(model(vals[0]));
    tick();
    vin = 2.9;
    wait_valid(20, n);
    n_checks++;
    if (valid !== 1'b1 || n != 6) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: valid=%0b after %0d clocks, required 1 after 6", valid, n);
    end
    for (int i = 1; i < 3; i++) begin
      vin = vals[i];
      exp_q.push_back(model(vals[i]));
      tick();
      vin = 2.9;
      if (i == 2) start = 1'b0;
      n_checks++;
      if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_pulse_%0d: valid=%0b required 0", i, valid); end
      n = 1;
      while (!valid && n < 20) begin
        tick();
        n++;
      end
      n_checks++;
      if (valid !== 1'b1 || n != 7) begin
        n_fail++;
        $display("[TB] FAIL b2b_period_%0d: valid=%0b after %0d clocks, required 1 after 7", i, valid, n);
      end
    end
    tick();
  endtask

  task automatic test_abort_rstn();
    int n;
    bit saw_valid;
    start_conv(1.0);
    tick();
    tick();
    rstn = 1'b0;
    #1;
    exp_q.pop_back();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || out !== '0) begin
      n_fail++;
      $display("[TB] FAIL rstn_abort: busy=%0b valid=%0b out=%0d, required 0 0 0", busy, valid, out);
    end
    tick();
    rstn = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstn_no_valid: activity seen after abort, required none"); end
    start_conv(-1.0);
    wait_valid(20, n);
    n_checks++;
    if (valid !== 1'b1 || n != 6 || out !== 6'd21) begin
      n_fail++;
      $display("[TB] FAIL rstn_recover: valid=%0b n=%0d out=%0d, required 1 6 21", valid, n, out);
    end
    tick();
  endtask

  task automatic test_abort_pd();
    int n;
    start_conv(0.5);
    tick();
    tick();
    pd = 1'b1;
    #1;
    exp_q.pop_back();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || out !== '0) begin
      n_fail++;
      $display("[TB] FAIL pd_abort: busy=%0b valid=%0b out=%0d, required 0 0 0", busy, valid, out);
    end
    tick();
    start = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL pd_start_ignored: busy=%0b required 0", busy); end
    start = 1'b0;
    pd    = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL pd_release: busy=%0b valid=%0b, required 0 0", busy, valid);
    end
    start_conv(-2.5);
    wait_valid(20, n);
    n_checks++;
    if (valid !== 1'b1 || n != 6 || out !== 6'd5) begin
      n_fail++;
      $display("[TB] FAIL pd_recover: valid=%0b n=%0d out=%0d, required 1 6 5", valid, n, out);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_thresholds();
    test_ovr();
    test_back_to_back();
    test_abort_rstn();
    test_abort_pd();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL sb_drain: %0d results outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
